// File: rtl/io_pkg.sv
// Shared constants and types for the input-scan block.
package io_pkg;
    localparam int         IO_DATA_W     = 32;
    localparam logic [5:0] IO_STATUS_IDX = 6'h3F;
    localparam int         IO_NPORTS_DEF = 3;
    localparam int         IO_DB_W       = 4;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_PORT,
        RD_STATUS
    } rd_sel_e;
endpackage

// File: rtl/io_port_sampler.sv
// Per-port 2-flop synchronizer, optional debounce (IO_SCAN_DEBOUNCE_EN) and latched value.
// Latency: 2 sync cycles, then latches on the cycle scan_en selects this port (DB_CNT scans with debounce).
// Backpressure: none; load is a single-cycle strobe to the parent.
module io_port_sampler
    import io_pkg::*;
#(
    parameter int DB_CNT = 4
) (
    input  logic                 io_clk,
    input  logic                 resetn,
    input  logic [IO_DATA_W-1:0] in_raw,
    input  logic                 scan_en,
    output logic [IO_DATA_W-1:0] in_reg,
    output logic                 load
);
    logic [IO_DATA_W-1:0] sync1_q, sync1_d;
    logic [IO_DATA_W-1:0] sync2_q, sync2_d;
    logic [IO_DATA_W-1:0] in_reg_q, in_reg_d;

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            in_reg_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            in_reg_q <= in_reg_d;
        end
    end

`ifdef IO_SCAN_DEBOUNCE_EN
    localparam logic [IO_DB_W-1:0] DB_LIM = IO_DB_W'(DB_CNT);

    logic [IO_DATA_W-1:0] cand_q, cand_d;
    logic [IO_DB_W-1:0]   cnt_q, cnt_d;

    // A run of identical differing samples counts up; any other sample restarts it.
    always_comb begin
        sync1_d  = in_raw;
        sync2_d  = sync1_q;
        in_reg_d = in_reg_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        if (scan_en) begin
            if (sync2_q == in_reg_q) begin
                cnt_d = '0;
            end else begin
                if (cnt_q != '0 && cand_q == sync2_q) begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + IO_DB_W'(1);
                end else begin
                    cand_d = sync2_q;
                    cnt_d  = IO_DB_W'(1);
                end
                if (cnt_d >= DB_LIM) begin
                    load     = 1'b1;
                    in_reg_d = sync2_q;
                    cnt_d    = '0;
                end
            end
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    localparam int unused_db_cnt = DB_CNT;

    always_comb begin
        sync1_d  = in_raw;
        sync2_d  = sync1_q;
        load     = scan_en && (sync2_q != in_reg_q);
        in_reg_d = load ? sync2_q : in_reg_q;
    end
`endif

    assign in_reg = in_reg_q;
endmodule

// File: rtl/io_input_scan.sv
// Round-robin input scanner with pending flags, irq and a CPU read port (debounce via IO_SCAN_DEBOUNCE_EN).
// Latency: reads return on the next cycle; irq follows pending by one cycle.
// Backpressure: none; a read is accepted every cycle rd_en is high.
module io_input_scan
    import io_pkg::*;
#(
    parameter int NPORTS = IO_NPORTS_DEF,
    parameter int DB_CNT = 4
) (
    input  logic                             io_clk,
    input  logic                             resetn,
    input  logic [NPORTS-1:0][IO_DATA_W-1:0] in_port,
    input  logic                             rd_en,
    input  logic [31:0]                      addr,
    output logic [IO_DATA_W-1:0]             io_read_data,
    output logic                             rd_valid,
    output logic [NPORTS-1:0]                pending,
    output logic                             irq
);
    localparam int SW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [SW-1:0]                    scan_idx_q, scan_idx_d;
    logic [NPORTS-1:0]                pending_q, pending_d;
    logic                             irq_q, irq_d;
    logic                             rd_valid_q, rd_valid_d;
    logic [IO_DATA_W-1:0]             rdata_q, rdata_d;
    logic [NPORTS-1:0][IO_DATA_W-1:0] in_reg;
    logic [NPORTS-1:0]                load;
    logic [NPORTS-1:0]                clr;
    logic [5:0]                       rd_idx;
    rd_sel_e                          rd_sel;
    logic                             unused_addr;

    assign rd_idx      = addr[7:2];
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        io_port_sampler #(.DB_CNT(DB_CNT)) u_sampler (
            .io_clk  (io_clk),
            .resetn  (resetn),
            .in_raw  (in_port[i]),
            .scan_en (scan_idx_q == SW'(i)),
            .in_reg  (in_reg[i]),
            .load    (load[i])
        );
    end

    // Read data is taken from in_reg before this edge's load, and a load beats a clear.
    always_comb begin
        scan_idx_d = (scan_idx_q == SW'(NPORTS - 1)) ? '0 : scan_idx_q + SW'(1);
        rd_sel     = RD_NONE;
        clr        = '0;
        rdata_d    = rdata_q;
        rd_valid_d = rd_en;
        if (rd_idx < 6'(NPORTS)) begin
            rd_sel = RD_PORT;
        end else if (rd_idx == IO_STATUS_IDX) begin
            rd_sel = RD_STATUS;
        end
        if (rd_en) begin
            rdata_d = '0;
            for (int i = 0; i < NPORTS; i++) begin
                if (rd_sel == RD_PORT && rd_idx == 6'(i)) begin
                    clr[i]  = 1'b1;
                    rdata_d = in_reg[i];
                end
            end
            if (rd_sel == RD_STATUS) begin
                rdata_d = IO_DATA_W'(pending_q);
            end
        end
        pending_d = (pending_q & ~clr) | load;
        irq_d     = |pending_q;
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            scan_idx_q <= '0;
            pending_q  <= '0;
            irq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            scan_idx_q <= scan_idx_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
            rd_valid_q <= rd_valid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign io_read_data = rdata_q;
    assign rd_valid     = rd_valid_q;
    assign pending      = pending_q;
    assign irq          = irq_q;
endmodule

// File: tb/tb_io_input_scan.sv
// Directed bench for io_input_scan: read responses go through a scoreboard queue checked by a monitor.
module tb_io_input_scan;
    localparam int NP = 3;
`ifdef IO_SCAN_DEBOUNCE_EN
    localparam int DBN = 4;
`else
    localparam int DBN = 1;
`endif

    logic                 io_clk;
    logic                 resetn;
    logic [NP-1:0][31:0]  in_port;
    logic                 rd_en;
    logic [31:0]          addr;
    logic [31:0]          io_read_data;
    logic                 rd_valid;
    logic [NP-1:0]        pending;
    logic                 irq;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          used;
    logic [31:0] exp_q[$];

    io_input_scan #(.NPORTS(NP), .DB_CNT(DBN)) dut (
        .io_clk       (io_clk),
        .resetn       (resetn),
        .in_port      (in_port),
        .rd_en        (rd_en),
        .addr         (addr),
        .io_read_data (io_read_data),
        .rd_valid     (rd_valid),
        .pending      (pending),
        .irq          (irq)
    );

    initial begin
        io_clk = 1'b0;
        forever #5 io_clk = ~io_clk;
    end

    // Cycle c after reset release evaluates port (c-1) % NP.
    always @(posedge io_clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge io_clk) begin
        if (resetn && rd_valid) begin
            if (exp_q.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid), 32'h0);
            else                   chk("rd_data", io_read_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        rd_en = 1'b1;
        addr  = a;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_pend(input int b, input int maxc, output int posedges);
        int n;
        n = 0;
        do begin
            @(negedge io_clk);
            n++;
        end while (!pending[b] && n < maxc);
        posedges = n - 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn  = 1'b1;
        rd_en   = 1'b0;
        addr    = '0;
        in_port = '0;
        #1 resetn = 1'b0;
        #2;
        chk("reset_rdata",   io_read_data, 32'h0);
        chk("reset_rdvalid", 32'(rd_valid), 32'h0);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_irq",     32'(irq), 32'h0);
        repeat (3) @(posedge io_clk);
        @(negedge io_clk) resetn = 1'b1;
        tick();

        // Port 1 change reaches pending, irq follows one cycle later.
        in_port[1] = 32'hA5A5_0001;
        wait_pend(1, 20, used);
        chk("p1_latency_ok", 32'(used <= ((DBN == 1) ? 5 : 15)), 32'h1);
        chk("p1_pending",    32'(pending), 32'h2);
        chk("p1_irq_lag",    32'(irq), 32'h0);
        @(negedge io_clk);
        chk("p1_irq",        32'(irq), 32'h1);

        // Read port 1: data, clear, irq drops one cycle after.
        tick();
        rd(32'h4, 32'hA5A5_0001);
        @(negedge io_clk);
        chk("rd1_pending_clr", 32'(pending), 32'h0);
        chk("rd1_irq_hold",    32'(irq), 32'h1);
        @(negedge io_clk);
        chk("rd1_irq_clr",     32'(irq), 32'h0);

        // Port 2 update lands on the same edge as its clearing read.
        tick();
        in_port[2] = 32'h3;
        wait_pend(2, 20, used);
        chk("p2_pending", 32'(pending), 32'h4);
        tick();
        while (cyc % NP != 0) tick();
        in_port[2] = 32'h7;
        repeat (2 + NP * (DBN - 1)) tick();
        rd(32'h8, 32'h3);
        @(negedge io_clk);
        chk("set_wins_pending", 32'(pending), 32'h4);
        tick();
        rd(32'h8, 32'h7);
        @(negedge io_clk);
        chk("p2_cleared", 32'(pending), 32'h0);

`ifdef IO_SCAN_DEBOUNCE_EN
        // Bouncing input never latches; a stable value does.
        tick();
        for (int k = 0; k < 7; k++) begin
            in_port[0] = (k % 2 == 1) ? 32'h2 : 32'h1;
            repeat (3) tick();
        end
        chk("bounce_no_pend", 32'(pending[0]), 32'h0);
        in_port[0] = 32'h2;
        wait_pend(0, 25, used);
        chk("bounce_latency_ok", 32'(used <= 15), 32'h1);
        chk("bounce_pend", 32'(pending[0]), 32'h1);
        tick();
        rd(32'h0, 32'h2);
`endif

        // Reset during a read: async clear, no rd_valid after, scan from port 0.
        tick();
        in_port[0] = 32'h11;
        rd_en = 1'b1;
        addr  = 32'h8;
        tick();
        #2 resetn = 1'b0;
        #1;
        rd_en = 1'b0;
        chk("mid_rst_rdvalid", 32'(rd_valid), 32'h0);
        chk("mid_rst_rdata",   io_read_data, 32'h0);
        chk("mid_rst_pending", 32'(pending), 32'h0);
        chk("mid_rst_irq",     32'(irq), 32'h0);
        @(posedge io_clk);
        @(negedge io_clk) resetn = 1'b1;
        repeat (3 + NP * (DBN - 1)) @(posedge io_clk);
        @(negedge io_clk);
        chk("restart_rdvalid", 32'(rd_valid), 32'h0);
        chk("restart_order",   32'(pending), 32'h4);
        repeat (2) @(negedge io_clk);
        chk("restart_all",     32'(pending), 32'h7);

        // Status read does not clear; unmapped index reads zero.
        tick();
        rd(32'h4,  32'hA5A5_0001);
        rd(32'hFC, 32'h5);
        rd(32'h40, 32'h0);
        @(negedge io_clk);
        chk("status_no_clr", 32'(pending), 32'h5);
        tick();
        rd(32'h0, 32'h11);
        @(negedge io_clk);
        chk("p0_cleared", 32'(pending), 32'h4);

        repeat (2) @(negedge io_clk);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/io_input_scan.md
IO_INPUT_SCAN -- requirements
Module: io_input_scan

Interface
REQ-001 Parameter NPORTS, default 3, number of input ports (1..8).
REQ-002 Parameter DB_CNT, default 4, debounce stability count in scans (1..15).
REQ-003 io_clk  input  1  sole clock; all state updates on posedge io_clk.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 in_port0..in_port(NPORTS-1)  input  32 each  raw external input ports, asynchronous to io_clk.
REQ-006 rd_en  input  1  CPU read strobe, one request per asserted cycle.
REQ-007 addr  input  32  CPU address; only addr[7:2] decoded.
REQ-008 io_read_data  output  32  registered read data.
REQ-009 rd_valid  output  1  io_read_data valid, one-cycle pulse per accepted read.
REQ-010 pending  output  NPORTS  per-port "new value since last read" flags.
REQ-011 irq  output  1  registered OR of pending.

Function
REQ-012 Each in_portN SHALL pass through a two-flop synchronizer before any use.
REQ-013 A scan index SHALL advance by one each cycle, 0..NPORTS-1, then wrap to 0; only the indexed port is evaluated that cycle.
REQ-014 If the scanned port's synchronized value differs from its latched register in_regN (after debounce, REQ-025), in_regN SHALL load that value and pending[N] SHALL set on the same edge.
REQ-015 A read with rd_en=1 and addr[7:2]=k<NPORTS SHALL drive io_read_data=in_regk and rd_valid=1 on the next cycle, and SHALL clear pending[k].
REQ-016 A read with addr[7:2]=6'h3F SHALL return {zeros, pending} without clearing any flag.
REQ-017 A read at any other index SHALL return 32'h0 with rd_valid=1.
REQ-018 Reads SHALL be accepted back-to-back every cycle; fixed latency 1.
REQ-019 Set and clear of the same pending bit in one cycle: set wins; read data is the pre-update in_regk.
REQ-020 irq SHALL equal |pending, registered one cycle after pending.
REQ-021 Worst-case change-to-pending latency without debounce: 2 sync + NPORTS scan cycles.
REQ-022 rd_valid SHALL be 0 in any cycle not following an accepted read.

Reset
REQ-023 On resetn=0, immediately and regardless of clock: in_reg*, synchronizers, debounce counters, scan index, pending, irq, rd_valid, io_read_data SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard in-flight reads (no rd_valid after release); first scan after release SHALL be port 0.

Configuration
REQ-025 With IO_SCAN_DEBOUNCE_EN defined, a port SHALL latch only after its synchronized value differs from in_regN and is identical across DB_CNT consecutive scans of that port; a different candidate restarts the count at 1; counter saturates and clears on latch.
REQ-026 Without IO_SCAN_DEBOUNCE_EN, a port SHALL latch on the first differing scan and no debounce counters SHALL exist.

Structure
REQ-027 Shared package io_pkg SHALL hold IO_DATA_W=32, IO_STATUS_IDX=6'h3F, and the default NPORTS.
REQ-028 Per-port synchronizer and debounce logic SHALL be a sub-module io_port_sampler, instantiated NPORTS times; scan, pending, and read decode remain in io_input_scan.

Verification
REQ-029 Reset, then drive in_port1=32'hA5A5_0001 steady -> pending=3'b010 within 5 cycles without debounce, within 2+4*3 scans+1 with debounce; irq=1 one cycle later.
REQ-030 Read addr=32'h4 after REQ-029 -> next cycle io_read_data=32'hA5A5_0001, rd_valid=1, pending=0, irq=0 one cycle after.
REQ-031 Change in_port2 to 32'h7 in the cycle its pending bit is cleared by a read -> pending[2] remains 1, returned data is the old value.
REQ-032 Debounce on: toggle in_port0 between 1 and 2 every scan for 20 cycles -> in_reg0 unchanged, pending[0]=0; hold 2 for 4 scans -> latches 2.
REQ-033 Reads at addr 32'hFC with pending=3'b101, then 32'h40 -> 32'h5 (no clear), then 32'h0; both rd_valid=1.
REQ-034 Assert resetn=0 for one cycle during a read -> outputs 0 asynchronously, no rd_valid after release, scan restarts at port 0.
